// File: rtl/scaffold_fn_udiv_pkg.sv
// Shared types and sizing for the sequential 64/32 unsigned restoring divider.
package scaffold_fn_udiv_pkg;

    localparam int DEF_DIN0_W = 64;
    localparam int DEF_DIN1_W = 32;
    localparam int DEF_DOUT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Counter must hold values up to dout width inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/scaffold_fn_udiv_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, emit one quotient bit.
module scaffold_fn_udiv_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] part,
    input  logic [W-1:0] shift,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] part_next,
    output logic [W-1:0] shift_next
);

    logic [W:0] trial_s;
    logic [W:0] diff_s;
    logic       qbit_s;

    // Compare/subtract on the widened partial remainder so the carried-out bit is not lost.
    always_comb begin
        trial_s = {part, shift[W-1]};
        diff_s  = trial_s - {1'b0, divisor};
        qbit_s  = (trial_s >= {1'b0, divisor});
        if (qbit_s) begin
            part_next = diff_s[W-1:0];
        end else begin
            part_next = trial_s[W-1:0];
        end
        shift_next = {shift[W-2:0], qbit_s};
    end

endmodule

// File: rtl/scaffold_fn_udiv_64ns_32ns_32_seq.sv
// Sequential unsigned divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock, valid/ready handshakes.
module scaffold_fn_udiv_64ns_32ns_32_seq
    import scaffold_fn_udiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = DEF_DOUT_W,
    parameter int din0_WIDTH = DEF_DIN0_W,
    parameter int din1_WIDTH = DEF_DIN1_W,
    parameter int dout_WIDTH = DEF_DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [dout_WIDTH-1:0] rem,
    output logic                  div_zero,
    output logic                  ovf
);

    localparam int CNT_W = cnt_width(dout_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_STAGE - 1);

    if ((ID < 0) || (NUM_STAGE != dout_WIDTH) || (din0_WIDTH != 2 * din1_WIDTH)
        || (dout_WIDTH != din1_WIDTH)) begin : g_bad_config
        $error("scaffold_fn_udiv: inconsistent width parameters");
    end

    state_e                state_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [din1_WIDTH-1:0] part_r;
    logic [dout_WIDTH-1:0] shift_r;
    logic [din1_WIDTH-1:0] divisor_r;
    logic [dout_WIDTH-1:0] dout_r;
    logic [dout_WIDTH-1:0] rem_r;
    logic                  div_zero_r;
    logic                  ovf_r;

    logic [din1_WIDTH-1:0] upper_s;
    logic [dout_WIDTH-1:0] lower_s;
    logic [din1_WIDTH-1:0] step_part_s;
    logic [dout_WIDTH-1:0] step_shift_s;

    assign upper_s = din0[din0_WIDTH-1 -: din1_WIDTH];
    assign lower_s = din0[dout_WIDTH-1:0];

    scaffold_fn_udiv_step #(
        .W (din1_WIDTH)
    ) u_step (
        .part       (part_r),
        .shift      (shift_r),
        .divisor    (divisor_r),
        .part_next  (step_part_s),
        .shift_next (step_shift_s)
    );

    // Control FSM plus working datapath and registered result/handshake outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cnt_r       <= '0;
            part_r      <= '0;
            shift_r     <= '0;
            divisor_r   <= '0;
            dout_r      <= '0;
            rem_r       <= '0;
            div_zero_r  <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        divisor_r  <= din1;
                        in_ready_r <= 1'b0;
                        if (din1 == '0) begin
                            dout_r      <= '1;
                            rem_r       <= lower_s;
                            div_zero_r  <= 1'b1;
                            ovf_r       <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else if (upper_s >= din1) begin
                            // Quotient would need more than dout_WIDTH bits.
                            dout_r      <= '1;
                            rem_r       <= '0;
                            div_zero_r  <= 1'b0;
                            ovf_r       <= 1'b1;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            part_r  <= upper_s;
                            shift_r <= lower_s;
                            cnt_r   <= '0;
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    part_r  <= step_part_s;
                    shift_r <= step_shift_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_ITER) begin
                        dout_r      <= step_shift_s;
                        rem_r       <= step_part_s;
                        div_zero_r  <= 1'b0;
                        ovf_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign dout      = dout_r;
    assign rem       = rem_r;
    assign div_zero  = div_zero_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_scaffold_fn_udiv_64ns_32ns_32_seq.sv
// Directed and random self-checking bench for the sequential 64/32 unsigned divider.
module tb_scaffold_fn_udiv_64ns_32ns_32_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] din0;
    logic [31:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;
    logic [31:0] rem;
    logic        div_zero;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    scaffold_fn_udiv_64ns_32ns_32_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .rem       (rem),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 ap_clk = ~ap_clk;

    // Issue one operation; operands are scrambled after accept. lat = edges after the accept edge until out_valid.
    task automatic do_op(input logic [63:0] a, input logic [31:0] b, input bit hold,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov, output int lat);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge ap_clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
        end
        din0 = a; din1 = b; in_valid = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0; din0 = ~a; din1 = ~b;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge ap_clk); #1; lat++;
        end
        if (lat >= 100) begin
            checks++; failures++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
        q = dout; r = rem; dz = div_zero; ov = ovf;
        if (!hold) begin
            out_ready = 1'b1;
            @(posedge ap_clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din0 = 64'h0; din1 = 32'h0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 32'h0 || rem !== 32'h0
            || div_zero !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h dz=%b ov=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, dout, rem, div_zero, ovf);
        end
    endtask

    task automatic test_divide();
        logic [63:0] a_tab [4] = '{64'h0000_0000_0000_0064, 64'hFFFF_FFFE_FFFF_FFFF,
                                   64'h0000_0001_0000_0000, 64'h0000_0004_FFFF_FFFF};
        logic [31:0] b_tab [4] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd5};
        logic [31:0] q_tab [4] = '{32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] r_tab [4] = '{32'd2, 32'hFFFF_FFFE, 32'd0, 32'd4};
        logic [31:0] q, r;
        logic dz, ov;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(a_tab[i], b_tab[i], 1'b0, q, r, dz, ov, lat);
            checks++;
            if (q !== q_tab[i] || r !== r_tab[i] || dz !== 1'b0 || ov !== 1'b0 || lat != 32) begin
                failures++;
                $display("FAIL divide_%0d: q=%h r=%h dz=%b ov=%b lat=%0d required q=%h r=%h 0 0 lat=32",
                         i, q, r, dz, ov, lat, q_tab[i], r_tab[i]);
            end
        end
    endtask

    task automatic test_zero_ovf();
        logic [31:0] q, r;
        logic dz, ov;
        int lat;
        do_op(64'h1234_5678_9ABC_DEF0, 32'h0, 1'b0, q, r, dz, ov, lat);
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h9ABC_DEF0 || dz !== 1'b1 || ov !== 1'b0 || lat != 0) begin
            failures++;
            $display("FAIL div_zero: q=%h r=%h dz=%b ov=%b lat=%0d required ffffffff 9abcdef0 1 0 lat=0",
                     q, r, dz, ov, lat);
        end
        do_op(64'h0000_0005_0000_0000, 32'd5, 1'b0, q, r, dz, ov, lat);
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h0 || dz !== 1'b0 || ov !== 1'b1 || lat != 0) begin
            failures++;
            $display("FAIL overflow: q=%h r=%h dz=%b ov=%b lat=%0d required ffffffff 0 0 1 lat=0",
                     q, r, dz, ov, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r;
        logic dz, ov;
        int lat;
        do_op(64'd100, 32'd7, 1'b1, q, r, dz, ov, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge ap_clk); #1;
            checks++;
            if (dout !== 32'd14 || rem !== 32'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d: q=%h r=%h vld=%b rdy=%b required e 2 1 0",
                         i, dout, rem, out_valid, in_ready);
            end
        end
        out_ready = 1'b1; in_valid = 1'b1; din0 = 64'd1003; din1 = 32'd10;
        @(posedge ap_clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL retire_no_accept: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reaccept_next_edge: rdy=%b required 0", in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge ap_clk); #1; lat++;
        end
        checks++;
        if (dout !== 32'd100 || rem !== 32'd3 || lat != 32) begin
            failures++;
            $display("FAIL reaccept_result: q=%0d r=%0d lat=%0d required 100 3 lat=32", dout, rem, lat);
        end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_mid_calc_reset();
        int seen;
        din0 = 64'd100; din1 = 32'd7; in_valid = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== 32'h0 || rem !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: vld=%b q=%h r=%h required 0 0 0", out_valid, dout, rem);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: rdy=%b required 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL stale_result: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [31:0] b, hi, q, r;
        logic dz, ov;
        int lat;
        logic [63:0] recon;
        for (int i = 0; i < 1000; i++) begin
            b = $urandom;
            if (b == 32'h0) b = 32'd1;
            hi = $urandom % b;
            a = {hi, 32'($urandom)};
            do_op(a, b, 1'b0, q, r, dz, ov, lat);
            recon = ({32'h0, b} * {32'h0, q}) + {32'h0, r};
            checks++;
            if (recon !== a || r >= b || dz !== 1'b0 || ov !== 1'b0 || lat != 32) begin
                failures++;
                $display("FAIL random_%0d: a=%h b=%h q=%h r=%h dz=%b ov=%b lat=%0d required b*q+r==a r<b 0 0 lat=32",
                         i, a, b, q, r, dz, ov, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_zero_ovf();
        test_back_to_back();
        test_mid_calc_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scaffold_fn_udiv_64ns_32ns_32_seq.md
SCAFFOLD_FN_UDIV_64NS_32NS_32_SEQ -- requirements
Module: scaffold_fn_udiv_64ns_32ns_32_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter NUM_STAGE, default 32, nominal iteration count, always equal to dout_WIDTH.
REQ-003 SHALL have parameter din0_WIDTH, default 64, dividend width, always 2*din1_WIDTH.
REQ-004 SHALL have parameter din1_WIDTH, default 32, divisor width.
REQ-005 SHALL have parameter dout_WIDTH, default 32, quotient and remainder width, always equal to din1_WIDTH.
REQ-006 SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have port in_valid, input, 1 bit: din0/din1 valid.
REQ-009 SHALL have port in_ready, output, 1 bit: operands accepted this cycle.
REQ-010 SHALL have port din0, input, din0_WIDTH: unsigned dividend (a full product word).
REQ-011 SHALL have port din1, input, din1_WIDTH: unsigned divisor.
REQ-012 SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-014 SHALL have port dout, output, dout_WIDTH: quotient.
REQ-015 SHALL have port rem, output, dout_WIDTH: remainder.
REQ-016 SHALL have port div_zero, output, 1 bit: divisor was zero.
REQ-017 SHALL have port ovf, output, 1 bit: quotient does not fit in dout_WIDTH.

Function
REQ-018 SHALL be an FSM with states IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-019 SHALL accept operands on an edge with in_valid&in_ready, latching din0 and din1 internally; later input changes have no effect.
REQ-020 SHALL detect at accept: din1==0 -> DONE, dout=all-ones, rem=din0[dout_WIDTH-1:0], div_zero=1, ovf=0.
REQ-021 SHALL detect at accept: din1!=0 and din0[upper half]>=din1 -> DONE, dout=all-ones, rem=0, ovf=1, div_zero=0.
REQ-022 SHALL otherwise load the remainder register with din0 upper half and the shift register with the lower half, clear the iteration counter, and enter CALC.
REQ-023 SHALL per CALC edge form t={rem,msb of shift reg} (din1_WIDTH+1 bits); if t>=divisor: rem=t-divisor and qbit=1, else rem=t[din1_WIDTH-1:0] and qbit=0; shift reg={shift<<1, qbit}.
REQ-024 SHALL leave CALC after exactly dout_WIDTH iterations, so out_valid rises after edge 32 counting the accept edge as 0; dout=floor(din0/din1), rem=din0 mod din1, flags 0.
REQ-025 SHALL hold dout, rem, div_zero and ovf stable throughout DONE until out_valid&out_ready, then go to IDLE on that edge.
REQ-026 SHALL NOT accept new operands on the edge that retires a result; the earliest re-accept is the following edge (in_ready=0 in DONE).
REQ-027 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-028 SHALL keep dout, rem and flags at the last result value in IDLE and CALC (not valid; qualified by out_valid).

Reset
REQ-029 SHALL on ap_rst_n=0, immediately and regardless of clock or state (including mid-CALC): go to IDLE, clear the counter and all datapath registers, drive dout=0, rem=0, div_zero=0, ovf=0 and out_valid=0, with in_ready=1 after release.
REQ-030 SHALL drop any in-flight operation on reset, with no result ever presented for it.

Structure
REQ-031 SHALL take the state enum (IDLE/CALC/DONE), the default widths and the iteration-count width (clog2(dout_WIDTH)+1) from a shared package scaffold_fn_udiv_pkg.
REQ-032 SHALL use one combinational sub-module, scaffold_fn_udiv_step (compare/subtract/shift for one quotient bit), instantiated once.

Verification
REQ-033 SHALL check: din0=0x0000_0000_0000_0064, din1=7 -> after 32 cycles dout=14, rem=2, flags 0.
REQ-034 SHALL check: din0=0xFFFF_FFFE_FFFF_FFFF, din1=0xFFFF_FFFF -> dout=0xFFFF_FFFF, rem=0xFFFF_FFFE, ovf=0.
REQ-035 SHALL check: din1=0, din0=0x1234_5678_9ABC_DEF0 -> out_valid 1 cycle after accept, dout=0xFFFF_FFFF, rem=0x9ABC_DEF0, div_zero=1; then din0=0x0000_0005_0000_0000, din1=5 -> ovf=1, dout=0xFFFF_FFFF, rem=0.
REQ-036 SHALL check: out_ready held low 10 cycles in DONE -> outputs stable and in_ready=0; retire, then in_valid held high -> next accept exactly one edge later.
REQ-037 SHALL check: ap_rst_n pulsed low mid-CALC (iteration 10) -> out_valid, dout and rem become 0 without a clock edge, in_ready=1 after release, and no stale result appears.
REQ-038 SHALL check: 1000 random operands with din0[upper half]<din1 -> din1*dout+rem==din0 and rem<din1.
